// File: rtl/decode.sv
// RV32I decode stage: registers immediates, register addresses and control fields one cycle after each request.
// Build option: define DECODE_ILLEGAL_INSTR_EN to add the illegal_o flag output.
module decode (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] instr_rdata_i,
  output logic [31:0] imm_i_type_o,
  output logic [31:0] imm_s_type_o,
  output logic [31:0] imm_b_type_o,
  output logic [31:0] imm_u_type_o,
  output logic [31:0] imm_j_type_o,
  output logic [31:0] imm_o_type_o,
  output logic [31:0] imm_n_type_o,
  output logic        req_rf_ra_o,
  output logic        req_rf_rb_o,
  output logic [4:0]  rf_raddr_a_o,
  output logic [4:0]  rf_raddr_b_o,
  output logic [4:0]  rf_waddr_o,
  output logic        req_data_o,
  output logic        we_data_o,
  output logic        req_pc_alu_o,
  output logic [1:0]  operateur_pc_alu_o,
  output logic        req_alu_o,
  output logic [4:0]  operateur_alu_o,
  output logic [1:0]  type_operand_a_o,
  output logic        type_operand_b_o,
  output logic [2:0]  type_imm_b_o
`ifdef DECODE_ILLEGAL_INSTR_EN
  ,
  output logic        illegal_o
`endif
);

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_XOR = 5'd2, ALU_OR = 5'd3,
    ALU_AND = 5'd4, ALU_SLL = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
    ALU_SLT = 5'd8, ALU_SLTU = 5'd9, ALU_EQ = 5'd10, ALU_NE = 5'd11,
    ALU_LT = 5'd12, ALU_GE = 5'd13, ALU_LTU = 5'd14, ALU_GEU = 5'd15
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
    OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
    OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011
  } opcode_e;

  typedef struct packed {
    logic [31:0] immI, immS, immB, immU, immJ, immO, immN;
    logic        reqRa, reqRb;
    logic [4:0]  raddrA, raddrB, waddr;
    logic        reqData, weData, reqPc;
    logic [1:0]  pcOp;
    logic        reqAlu;
    logic [4:0]  aluOp;
    logic [1:0]  opA;
    logic        opB;
    logic [2:0]  immSel;
`ifdef DECODE_ILLEGAL_INSTR_EN
    logic        illegal;
`endif
  } dec_t;

  dec_t       out_q, out_d;
  logic       bad;
  logic [2:0] f3;
  logic [4:0] rd;

  // alt picks SUB over ADD and SRA over SRL
  function automatic logic [4:0] aluFromF3(input logic [2:0] fn, input logic alt);
    case (fn)
      3'd0:    aluFromF3 = alt ? ALU_SUB : ALU_ADD;
      3'd1:    aluFromF3 = ALU_SLL;
      3'd2:    aluFromF3 = ALU_SLT;
      3'd3:    aluFromF3 = ALU_SLTU;
      3'd4:    aluFromF3 = ALU_XOR;
      3'd5:    aluFromF3 = alt ? ALU_SRA : ALU_SRL;
      3'd6:    aluFromF3 = ALU_OR;
      default: aluFromF3 = ALU_AND;
    endcase
  endfunction

  assign f3 = instr_rdata_i[14:12];
  assign rd = instr_rdata_i[11:7];

  // Without a request, request strobes drop and everything else holds.
  always_comb begin
    out_d         = out_q;
    out_d.reqRa   = 1'b0;
    out_d.reqRb   = 1'b0;
    out_d.reqData = 1'b0;
    out_d.reqPc   = 1'b0;
    out_d.reqAlu  = 1'b0;
    bad           = 1'b0;
    if (req_i) begin
      out_d        = '0;
      out_d.immI   = {{20{instr_rdata_i[31]}}, instr_rdata_i[31:20]};
      out_d.immS   = {{20{instr_rdata_i[31]}}, instr_rdata_i[31:25], instr_rdata_i[11:7]};
      out_d.immB   = {{19{instr_rdata_i[31]}}, instr_rdata_i[31], instr_rdata_i[7],
                      instr_rdata_i[30:25], instr_rdata_i[11:8], 1'b0};
      out_d.immU   = {instr_rdata_i[31:12], 12'b0};
      out_d.immJ   = {{11{instr_rdata_i[31]}}, instr_rdata_i[31], instr_rdata_i[19:12],
                      instr_rdata_i[20], instr_rdata_i[30:21], 1'b0};
      out_d.immO   = {27'b0, instr_rdata_i[24:20]};
      out_d.immN   = 32'd4;
      out_d.raddrA = instr_rdata_i[19:15];
      out_d.raddrB = instr_rdata_i[24:20];
      case (instr_rdata_i[6:0])
        OPC_LUI: begin
          out_d.opA = 2'd2; out_d.opB = 1'b1; out_d.immSel = 3'd3; out_d.waddr = rd;
        end
        OPC_AUIPC: begin
          out_d.opA = 2'd1; out_d.opB = 1'b1; out_d.immSel = 3'd3; out_d.waddr = rd;
        end
        OPC_JAL: begin
          out_d.opA = 2'd1; out_d.opB = 1'b1; out_d.immSel = 3'd6; out_d.waddr = rd;
          out_d.reqPc = 1'b1; out_d.pcOp = 2'd1;
        end
        OPC_JALR: begin
          out_d.opA = 2'd1; out_d.opB = 1'b1; out_d.immSel = 3'd6; out_d.waddr = rd;
          out_d.reqPc = 1'b1; out_d.pcOp = 2'd2; out_d.reqRa = 1'b1;
          bad = (f3 != 3'd0);
        end
        OPC_BRANCH: begin
          out_d.reqRa = 1'b1; out_d.reqRb = 1'b1; out_d.reqPc = 1'b1;
          out_d.pcOp = 2'd3; out_d.immSel = 3'd2;
          case (f3)
            3'd0:    out_d.aluOp = ALU_EQ;
            3'd1:    out_d.aluOp = ALU_NE;
            3'd4:    out_d.aluOp = ALU_LT;
            3'd5:    out_d.aluOp = ALU_GE;
            3'd6:    out_d.aluOp = ALU_LTU;
            3'd7:    out_d.aluOp = ALU_GEU;
            default: bad = 1'b1;
          endcase
        end
        OPC_LOAD: begin
          out_d.reqRa = 1'b1; out_d.opB = 1'b1; out_d.reqData = 1'b1; out_d.waddr = rd;
          bad = (f3 == 3'd3) || (f3 >= 3'd6);
        end
        OPC_STORE: begin
          out_d.reqRa = 1'b1; out_d.reqRb = 1'b1; out_d.opB = 1'b1; out_d.immSel = 3'd1;
          out_d.reqData = 1'b1; out_d.weData = 1'b1;
          bad = (f3 > 3'd2);
        end
        OPC_OPIMM: begin
          out_d.reqRa = 1'b1; out_d.opB = 1'b1; out_d.waddr = rd;
          out_d.aluOp = aluFromF3(f3, instr_rdata_i[30] && (f3 == 3'd5));
          out_d.immSel = ((f3 == 3'd1) || (f3 == 3'd5)) ? 3'd5 : 3'd0;
        end
        OPC_OP: begin
          out_d.reqRa = 1'b1; out_d.reqRb = 1'b1; out_d.waddr = rd;
          out_d.aluOp = aluFromF3(f3, instr_rdata_i[30] && ((f3 == 3'd0) || (f3 == 3'd5)));
        end
        default: bad = 1'b1;
      endcase
      out_d.reqAlu = !bad;
      // Unsupported encodings keep their immediates/addresses but drive no control.
      if (bad) begin
        out_d.reqRa = 1'b0; out_d.reqRb = 1'b0; out_d.reqData = 1'b0; out_d.weData = 1'b0;
        out_d.reqPc = 1'b0; out_d.pcOp = 2'd0; out_d.aluOp = 5'd0; out_d.waddr = 5'd0;
        out_d.opA = 2'd0; out_d.opB = 1'b0; out_d.immSel = 3'd0;
      end
`ifdef DECODE_ILLEGAL_INSTR_EN
      out_d.illegal = bad;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) out_q <= '0;
    else       out_q <= out_d;
  end

  assign imm_i_type_o       = out_q.immI;
  assign imm_s_type_o       = out_q.immS;
  assign imm_b_type_o       = out_q.immB;
  assign imm_u_type_o       = out_q.immU;
  assign imm_j_type_o       = out_q.immJ;
  assign imm_o_type_o       = out_q.immO;
  assign imm_n_type_o       = out_q.immN;
  assign req_rf_ra_o        = out_q.reqRa;
  assign req_rf_rb_o        = out_q.reqRb;
  assign rf_raddr_a_o       = out_q.raddrA;
  assign rf_raddr_b_o       = out_q.raddrB;
  assign rf_waddr_o         = out_q.waddr;
  assign req_data_o         = out_q.reqData;
  assign we_data_o          = out_q.weData;
  assign req_pc_alu_o       = out_q.reqPc;
  assign operateur_pc_alu_o = out_q.pcOp;
  assign req_alu_o          = out_q.reqAlu;
  assign operateur_alu_o    = out_q.aluOp;
  assign type_operand_a_o   = out_q.opA;
  assign type_operand_b_o   = out_q.opB;
  assign type_imm_b_o       = out_q.immSel;
`ifdef DECODE_ILLEGAL_INSTR_EN
  assign illegal_o          = out_q.illegal;
`endif

endmodule

// File: tb/tb_decode.sv
// Randomized self-checking bench for decode against a class-table reference model.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst, req;
  logic [31:0] instr;
  logic [31:0] immI, immS, immB, immU, immJ, immO, immN;
  logic        reqRa, reqRb, reqData, weData, reqPc, reqAlu, opB;
  logic [4:0]  raddrA, raddrB, waddr, aluOp;
  logic [1:0]  pcOp, opA;
  logic [2:0]  immSel;
  logic        illegal;
  logic        started = 1'b0;
  int          checks = 0;
  int          errors = 0;

  typedef enum {C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE, C_OPIMM, C_OP, C_BAD} cls_t;

  typedef struct {
    logic [31:0] immI, immS, immB, immU, immJ, immO, immN;
    logic        reqRa, reqRb, reqData, weData, reqPc, reqAlu, opB, illegal;
    logic [4:0]  raddrA, raddrB, waddr, aluOp;
    logic [1:0]  pcOp, opA;
    logic [2:0]  immSel;
  } exp_t;

  exp_t expQ;

  always #5 clk = ~clk;

  decode dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .instr_rdata_i(instr),
    .imm_i_type_o(immI), .imm_s_type_o(immS), .imm_b_type_o(immB), .imm_u_type_o(immU),
    .imm_j_type_o(immJ), .imm_o_type_o(immO), .imm_n_type_o(immN),
    .req_rf_ra_o(reqRa), .req_rf_rb_o(reqRb), .rf_raddr_a_o(raddrA), .rf_raddr_b_o(raddrB),
    .rf_waddr_o(waddr), .req_data_o(reqData), .we_data_o(weData), .req_pc_alu_o(reqPc),
    .operateur_pc_alu_o(pcOp), .req_alu_o(reqAlu), .operateur_alu_o(aluOp),
    .type_operand_a_o(opA), .type_operand_b_o(opB), .type_imm_b_o(immSel)
`ifdef DECODE_ILLEGAL_INSTR_EN
    , .illegal_o(illegal)
`endif
  );

`ifndef DECODE_ILLEGAL_INSTR_EN
  assign illegal = 1'b0;
`endif

  function automatic cls_t classify(input logic [31:0] w);
    int fn = int'(w[14:12]);
    case (w[6:0])
      7'h37:   return C_LUI;
      7'h17:   return C_AUIPC;
      7'h6F:   return C_JAL;
      7'h67:   return (fn == 0) ? C_JALR : C_BAD;
      7'h63:   return (fn == 2 || fn == 3) ? C_BAD : C_BRANCH;
      7'h03:   return (fn == 3 || fn >= 6) ? C_BAD : C_LOAD;
      7'h23:   return (fn <= 2) ? C_STORE : C_BAD;
      7'h13:   return C_OPIMM;
      7'h33:   return C_OP;
      default: return C_BAD;
    endcase
  endfunction

  // Reference decode: immediates by signed arithmetic, controls from per-class rows.
  function automatic exp_t modelDecode(input logic [31:0] w);
    exp_t        e;
    int          s = $signed(w);
    int          fn = int'(w[14:12]);
    int          aluTab[8] = '{0, 5, 8, 9, 2, 6, 3, 4};
    int          brTab[8] = '{10, 11, 0, 0, 12, 13, 14, 15};
    logic [31:0] t;
    cls_t        c = classify(w);
    e.immI = 32'(s >>> 20);
    t = 32'((s >>> 25) <<< 5);
    e.immS = t | 32'(w[11:7]);
    t = 32'((s >>> 31) <<< 12);
    e.immB = t | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    e.immU = w & 32'hFFFFF000;
    t = 32'((s >>> 31) <<< 20);
    e.immJ = t | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    e.immO = 32'(w[24:20]);
    e.immN = 32'd4;
    e.raddrA = w[19:15];
    e.raddrB = w[24:20];
    e.reqAlu = (c != C_BAD);
    e.illegal = (c == C_BAD);
    e.reqRa = c inside {C_JALR, C_BRANCH, C_LOAD, C_STORE, C_OPIMM, C_OP};
    e.reqRb = c inside {C_BRANCH, C_STORE, C_OP};
    e.reqData = c inside {C_LOAD, C_STORE};
    e.weData = (c == C_STORE);
    e.reqPc = c inside {C_JAL, C_JALR, C_BRANCH};
    e.pcOp = (c == C_JAL) ? 2'd1 : (c == C_JALR) ? 2'd2 : (c == C_BRANCH) ? 2'd3 : 2'd0;
    e.waddr = (c inside {C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_OPIMM, C_OP}) ? w[11:7] : 5'd0;
    e.opA = (c == C_LUI) ? 2'd2 : (c inside {C_AUIPC, C_JAL, C_JALR}) ? 2'd1 : 2'd0;
    e.opB = !(c inside {C_BRANCH, C_OP, C_BAD});
    case (c)
      C_LUI, C_AUIPC: e.immSel = 3'd3;
      C_JAL, C_JALR:  e.immSel = 3'd6;
      C_STORE:        e.immSel = 3'd1;
      C_BRANCH:       e.immSel = 3'd2;
      C_OPIMM:        e.immSel = (fn == 1 || fn == 5) ? 3'd5 : 3'd0;
      default:        e.immSel = 3'd0;
    endcase
    case (c)
      C_BRANCH: e.aluOp = 5'(brTab[fn]);
      C_OPIMM:  e.aluOp = 5'(aluTab[fn] + ((fn == 5 && w[30]) ? 1 : 0));
      C_OP:     e.aluOp = 5'(aluTab[fn] + (((fn == 0 || fn == 5) && w[30]) ? 1 : 0));
      default:  e.aluOp = 5'd0;
    endcase
    return e;
  endfunction

  function automatic exp_t zeroExp();
    exp_t e;
    e = '{immI: 0, immS: 0, immB: 0, immU: 0, immJ: 0, immO: 0, immN: 0,
          reqRa: 0, reqRb: 0, reqData: 0, weData: 0, reqPc: 0, reqAlu: 0, opB: 0, illegal: 0,
          raddrA: 0, raddrB: 0, waddr: 0, aluOp: 0, pcOp: 0, opA: 0, immSel: 0};
    return e;
  endfunction

  // Reference state: reset clears, request loads, idle drops only the strobes.
  always @(posedge clk) begin
    if (rst) expQ = zeroExp();
    else if (req) expQ = modelDecode(instr);
    else begin
      expQ.reqRa = 0; expQ.reqRb = 0; expQ.reqData = 0; expQ.reqPc = 0; expQ.reqAlu = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkOutput("imm_i", immI, expQ.immI);
      checkOutput("imm_s", immS, expQ.immS);
      checkOutput("imm_b", immB, expQ.immB);
      checkOutput("imm_u", immU, expQ.immU);
      checkOutput("imm_j", immJ, expQ.immJ);
      checkOutput("imm_o", immO, expQ.immO);
      checkOutput("imm_n", immN, expQ.immN);
      checkOutput("req_rf_ra", 32'(reqRa), 32'(expQ.reqRa));
      checkOutput("req_rf_rb", 32'(reqRb), 32'(expQ.reqRb));
      checkOutput("raddr_a", 32'(raddrA), 32'(expQ.raddrA));
      checkOutput("raddr_b", 32'(raddrB), 32'(expQ.raddrB));
      checkOutput("waddr", 32'(waddr), 32'(expQ.waddr));
      checkOutput("req_data", 32'(reqData), 32'(expQ.reqData));
      checkOutput("we_data", 32'(weData), 32'(expQ.weData));
      checkOutput("req_pc_alu", 32'(reqPc), 32'(expQ.reqPc));
      checkOutput("pc_op", 32'(pcOp), 32'(expQ.pcOp));
      checkOutput("req_alu", 32'(reqAlu), 32'(expQ.reqAlu));
      checkOutput("alu_op", 32'(aluOp), 32'(expQ.aluOp));
      checkOutput("op_a", 32'(opA), 32'(expQ.opA));
      checkOutput("op_b", 32'(opB), 32'(expQ.opB));
      checkOutput("imm_sel", 32'(immSel), 32'(expQ.immSel));
`ifdef DECODE_ILLEGAL_INSTR_EN
      checkOutput("illegal", 32'(illegal), 32'(expQ.illegal));
`endif
    end
  end

  task automatic applyStimulus(input logic r, input logic q, input logic [31:0] w);
    @(negedge clk);
    rst = r; req = q; instr = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0]  opcTab[9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [31:0] w;
    logic        illegalExp;
`ifdef DECODE_ILLEGAL_INSTR_EN
    illegalExp = 1'b1;
`else
    illegalExp = 1'b0;
`endif
    expQ = zeroExp();
    rst = 1'b1; req = 1'b0; instr = 32'h0;
    @(posedge clk); #1;
    started = 1'b1;
    checkOutput("reset imm_n", immN, 32'd0);
    checkOutput("reset req_alu", 32'(reqAlu), 32'd0);

    applyStimulus(1'b0, 1'b1, 32'h008000EF);
    checkOutput("jal imm_j", immJ, 32'd8);
    checkOutput("jal waddr", 32'(waddr), 32'd1);
    checkOutput("jal req_pc", 32'(reqPc), 32'd1);
    checkOutput("jal pc_op", 32'(pcOp), 32'd1);
    checkOutput("jal req_alu", 32'(reqAlu), 32'd1);
    checkOutput("jal alu_op", 32'(aluOp), 32'd0);
    checkOutput("jal op_a", 32'(opA), 32'd1);
    checkOutput("jal imm_sel", 32'(immSel), 32'd6);

    applyStimulus(1'b0, 1'b1, 32'h00008067);
    checkOutput("jalr req_ra", 32'(reqRa), 32'd1);
    checkOutput("jalr raddr_a", 32'(raddrA), 32'd1);
    checkOutput("jalr pc_op", 32'(pcOp), 32'd2);
    checkOutput("jalr imm_i", immI, 32'd0);
    checkOutput("jalr waddr", 32'(waddr), 32'd0);

    applyStimulus(1'b0, 1'b1, 32'h00208863);
    checkOutput("beq imm_b", immB, 32'd16);
    checkOutput("beq raddr_a", 32'(raddrA), 32'd1);
    checkOutput("beq raddr_b", 32'(raddrB), 32'd2);
    checkOutput("beq alu_op", 32'(aluOp), 32'd10);
    applyStimulus(1'b0, 1'b1, 32'h00209863);
    checkOutput("bne alu_op", 32'(aluOp), 32'd11);
    checkOutput("bne pc_op", 32'(pcOp), 32'd3);

    applyStimulus(1'b0, 1'b1, 32'hFE20AE23);
    checkOutput("sw imm_s", immS, 32'hFFFFFFFC);
    checkOutput("sw req_data", 32'(reqData), 32'd1);
    checkOutput("sw we_data", 32'(weData), 32'd1);
    checkOutput("sw waddr", 32'(waddr), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("idle req_data", 32'(reqData), 32'd0);
    checkOutput("idle we_data held", 32'(weData), 32'd1);

    applyStimulus(1'b0, 1'b1, 32'hFFFFFFFF);
    checkOutput("bad req_alu", 32'(reqAlu), 32'd0);
    checkOutput("bad req_pc", 32'(reqPc), 32'd0);
    checkOutput("bad req_ra", 32'(reqRa), 32'd0);
    checkOutput("bad illegal", 32'(illegal), 32'(illegalExp));

    applyStimulus(1'b1, 1'b1, 32'h008000EF);
    checkOutput("rst+req imm_j", immJ, 32'd0);
    checkOutput("rst+req req_pc", 32'(reqPc), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h008000EF);
    checkOutput("post-rst imm_n", immN, 32'd4);
    checkOutput("post-rst imm_j", immJ, 32'd8);

    for (int i = 0; i < 3000; i++) begin
      w = $urandom();
      if ($urandom_range(0, 9) != 0) w[6:0] = opcTab[$urandom_range(0, 8)];
      applyStimulus($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 75, w);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL have no parameters; its only build option is the macro in REQ-026.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, clock; one clock; reset is synchronous and active-high.
- rst_i, in, 1, synchronous active-high reset.
- req_i, in, 1, decode request.
- instr_rdata_i, in, 32, RV32I instruction.
- imm_i_type_o / imm_s_type_o / imm_b_type_o / imm_u_type_o / imm_j_type_o, out, 32 each, standard sign-extended RV32I immediates.
- imm_o_type_o, out, 32, zero-extended shamt instr[24:20].
- imm_n_type_o, out, 32, constant 4 (next-PC increment).
- req_rf_ra_o / req_rf_rb_o, out, 1 each, read rs1 / rs2.
- rf_raddr_a_o / rf_raddr_b_o, out, 5 each, instr[19:15] / instr[24:20].
- rf_waddr_o, out, 5, rd (instr[11:7]); 0 if no writeback.
- req_data_o, out, 1, memory access.
- we_data_o, out, 1, 1 = store.
- req_pc_alu_o, out, 1, PC ALU request.
- operateur_pc_alu_o, out, 2, PC ALU op.
- req_alu_o, out, 1, ALU request.
- operateur_alu_o, out, 5, ALU op.
- type_operand_a_o, out, 2, A source.
- type_operand_b_o, out, 1, B source.
- type_imm_b_o, out, 3, immediate selected for B.

Function
REQ-003 On a rising clk_i with req_i=1 and rst_i=0, the block SHALL register the decode of instr_rdata_i into every output (latency 1 cycle).
REQ-004 All req_*_o outputs SHALL be high for exactly the one cycle after an accepted request; all other outputs SHALL hold until the next accepted request.
REQ-005 Back-to-back requests (req_i high on consecutive edges) SHALL each be decoded, one per cycle.
REQ-006 The register address outputs and all seven immediates SHALL be computed for every accepted request, regardless of instruction class.
REQ-007 Encodings SHALL be:
- type_operand_a: 0=rs1, 1=PC, 2=zero.
- type_operand_b: 0=rs2, 1=immediate.
- type_imm_b: 0=I, 1=S, 2=B, 3=U, 4=J, 5=O, 6=N.
- PC ALU: 0=none, 1=PC+imm_j (JAL), 2=(rs1+imm_i)&~1 (JALR), 3=PC+imm_b (branch).
- ALU: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 EQ, 11 NE, 12 LT, 13 GE, 14 LTU, 15 GEU.
REQ-008 LUI SHALL decode as ADD, A=zero, B=imm U, rd written.
REQ-009 AUIPC SHALL decode as ADD, A=PC, B=imm U, rd written.
REQ-010 JAL SHALL decode as ADD, A=PC, B=imm N, rd written; req_pc_alu=1, op 1.
REQ-011 JALR (funct3 000) SHALL decode as JAL, plus req_rf_ra=1 and PC op 2.
REQ-012 Branches SHALL decode as: funct3 000/001/100/101/110/111 map to EQ/NE/LT/GE/LTU/GEU; A=rs1, B=rs2; ra=rb=1; PC op 3; rf_waddr=0.
REQ-013 Loads SHALL decode as ADD, A=rs1, B=imm I; req_data=1, we_data=0; rd written.
REQ-014 Stores SHALL decode as ADD, A=rs1, B=imm S; ra=rb=1; req_data=1, we_data=1; rf_waddr=0.
REQ-015 OP-IMM SHALL use the funct3 ALU op, A=rs1, B=imm I; SLLI/SRLI/SRAI SHALL use imm O, with instr[30] selecting SRA.
REQ-016 OP SHALL use A=rs1, B=rs2, with instr[30] selecting SUB/SRA.
REQ-017 All other opcodes or funct3 values SHALL assert no req_*_o and SHALL set rf_waddr=0.

Reset
REQ-020 While rst_i=1 at a rising edge, every output SHALL become 0, overriding req_i.
REQ-021 Reset mid-operation SHALL discard a pending decode; the first request accepted after reset SHALL decode normally.

Configuration
REQ-026 With DECODE_ILLEGAL_INSTR_EN defined, an extra output illegal_o (1 bit) SHALL register 1 for each request decoded under REQ-017, and 0 otherwise; without the macro the port SHALL be absent and REQ-017 decodes SHALL be silent.

Verification
REQ-030 JAL 0x008000EF -> next cycle: imm_j=8, rf_waddr=1, req_pc_alu=1, op=1, req_alu=1, ALU op=0, A=1, type_imm_b=6.
REQ-031 JALR 0x00008067 -> next cycle: req_rf_ra=1, raddr_a=1, PC op=2, imm_i=0, rf_waddr=0.
REQ-032 BEQ 0x00208863 then BNE 0x00209863 on consecutive cycles -> imm_b=16, ra=1, rb=2, ALU op 10 then 11, PC op 3.
REQ-033 SW 0xFE20AE23 -> imm_s=0xFFFFFFFC, req_data=1, we_data=1, rf_waddr=0.
REQ-034 Any request with rst_i=1 -> all outputs 0; 0xFFFFFFFF -> no requests asserted, and illegal_o=1 when the macro is defined.
